// File: rtl/bus_responder_if.sv
// Bus responder interface: request/response signals between master and responder.
interface bus_responder_if;
    logic [31:0] addr;
    logic        read_en;
    logic        write_en;
    logic [31:0] wdata;
    logic        byte_transfer;
    logic        instruction_fetch;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    modport master (
        output addr, read_en, write_en, wdata, byte_transfer, instruction_fetch,
        input  rdata, stall, err
    );

    modport slave (
        input  addr, read_en, write_en, wdata, byte_transfer, instruction_fetch,
        output rdata, stall, err
    );
endinterface

// File: rtl/bus_responder.sv
// Wait-state memory responder: N/S wait timing, byte/word writes, open-bus reads
// and a registered error pulse for out-of-range or conflicting requests.
module bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
    parameter int unsigned DEPTH_WORDS = 8192,
    parameter int unsigned N_WAIT      = 2,
    parameter int unsigned S_WAIT      = 1
) (
    input logic            clk,
    input logic            reset,
    bus_responder_if.slave bus
);

    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SpanBytes = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  NWait     = 4'(N_WAIT);
    localparam logic [3:0]  SWait     = 4'(S_WAIT);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            err_q;
    logic [31:0]     open_bus_q;
    logic            hist_valid_q;
    logic [31:0]     hist_addr_q;
    logic            hist_write_q;
    logic            hist_fetch_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            req;
    logic            both;
    logic            seq;
    logic [3:0]      wait_sel;
    logic            stall_c;
    logic            complete;
    logic            both_err;
    logic [31:0]     offset;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic [31:0]     rd_word;
    logic [31:0]     wr_word;
    logic            rd_hit;
    logic            mem_we;

    // FSM next state, wait counter and completion decode
    always_comb begin
        req      = bus.read_en ^ bus.write_en;
        both     = bus.read_en & bus.write_en;
        seq      = hist_valid_q && (hist_write_q == bus.write_en) &&
                   (hist_fetch_q == bus.instruction_fetch) &&
                   (bus.addr == hist_addr_q + 32'd4);
        wait_sel = seq ? SWait : NWait;
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        complete = 1'b0;
        both_err = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (wait_sel == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = wait_sel - 4'd1;
                        state_d = StWait;
                    end
                end else if (both) begin
                    both_err = 1'b1;
                end
            end
            StWait: begin
                if (!req) begin
                    // Master withdrew the request: abort without side effects
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
        // Reset takes effect combinationally so stall and commits drop at once
        if (reset) begin
            stall_c  = 1'b0;
            complete = 1'b0;
            both_err = 1'b0;
        end
    end

    // Address decode, read data and byte-lane merge for writes
    always_comb begin
        offset   = bus.addr - BASE_ADDR;
        in_range = offset < SpanBytes;
        idx      = offset[IdxW+1:2];
        rd_word  = mem_q[idx];
        wr_word  = bus.wdata;
        if (bus.byte_transfer) begin
            wr_word = rd_word;
            case (bus.addr[1:0])
                2'd0:    wr_word[7:0]   = bus.wdata[7:0];
                2'd1:    wr_word[15:8]  = bus.wdata[7:0];
                2'd2:    wr_word[23:16] = bus.wdata[7:0];
                default: wr_word[31:24] = bus.wdata[7:0];
            endcase
        end
        rd_hit    = complete && bus.read_en && in_range;
        mem_we    = complete && bus.write_en && in_range;
        bus.rdata = rd_hit ? rd_word : open_bus_q;
        bus.stall = stall_c;
        bus.err   = err_q;
    end

    // Control state, error pulse, open-bus value and sequential history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            err_q        <= 1'b0;
            open_bus_q   <= 32'd0;
            hist_valid_q <= 1'b0;
            hist_addr_q  <= 32'd0;
            hist_write_q <= 1'b0;
            hist_fetch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= both_err || (complete && !in_range);
            if (rd_hit) begin
                open_bus_q <= rd_word;
            end
            if (complete) begin
                hist_valid_q <= 1'b1;
                hist_addr_q  <= bus.addr;
                hist_write_q <= bus.write_en;
                hist_fetch_q <= bus.instruction_fetch;
            end
        end
    end

    // Backing store: not reset, written only on a completing in-range write
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed vector table, hand-written
// abort/reset sequences and randomized traffic against a transaction-level model.
module tb_bus_responder;

    localparam logic [31:0] Base = 32'h0300_0000;
    localparam longint      Span = 4 * 8192;
    localparam int          NW   = 2;
    localparam int          SW   = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_responder_if bus();

    bus_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        bt;
        logic        fetch;
        int          exp_stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    // Transaction-level reference state
    logic [31:0] m_mem [longint];
    logic        m_hv;
    logic [31:0] m_ha;
    logic        m_hwr;
    logic        m_hf;
    logic [31:0] m_open;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic bt, input logic f,
                              output int stalls, output logic [31:0] rdv,
                              output logic errv);
        logic done;
        bus.read_en           = rd;
        bus.write_en          = wr;
        bus.addr              = a;
        bus.wdata             = wd;
        bus.byte_transfer     = bt;
        bus.instruction_fetch = f;
        stalls = 0;
        rdv    = 32'd0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!bus.stall) begin
                rdv  = bus.rdata;
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: stall still 1 after 40 cycles, required completion");
        end
        @(posedge clk);
        #1;
        errv = bus.err;
    endtask

    task automatic idle_cycle();
        bus.read_en  = 1'b0;
        bus.write_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_access(input string name, input int st, input logic [31:0] rdv,
                                input logic ev, input int exp_st,
                                input logic [31:0] exp_rd, input logic exp_ev);
        check32({name, " stall"}, 32'(st), 32'(exp_st));
        check32({name, " rdata"}, rdv, exp_rd);
        check32({name, " err"}, {31'd0, ev}, {31'd0, exp_ev});
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(Base)) && (longint'(a) < longint'(Base) + Span);
    endfunction

    // Expected outcome of one transaction from the behavioural rules
    task automatic model_step(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic bt, input logic f,
                              output int exp_st, output logic [31:0] exp_rd,
                              output logic exp_e);
        logic   is_seq;
        longint k;
        logic [31:0] w;
        if (rd && wr) begin
            exp_st = 0;
            exp_rd = m_open;
            exp_e  = 1'b1;
            return;
        end
        is_seq = m_hv && (m_hwr == wr) && (m_hf == f) && (a == m_ha + 32'd4);
        exp_st = is_seq ? SW : NW;
        exp_e  = !in_rng(a);
        k      = (longint'(a) - longint'(Base)) / 4;
        if (rd && in_rng(a)) begin
            m_open = m_mem[k];
        end
        exp_rd = m_open;
        if (wr && in_rng(a)) begin
            if (bt) begin
                w = m_mem.exists(k) ? m_mem[k] : 32'd0;
                w[8*int'(a[1:0]) +: 8] = wd[7:0];
                m_mem[k] = w;
            end else begin
                m_mem[k] = wd;
            end
        end
        m_hv  = 1'b1;
        m_ha  = a;
        m_hwr = wr;
        m_hf  = f;
    endtask

    function automatic logic usable(input logic [31:0] a);
        return !in_rng(a) || (a >= Base && a < Base + 32'd64);
    endfunction

    vec_t vecs[$];
    int          st;
    logic [31:0] rdv;
    logic        ev;

    initial begin
        bus.read_en = 0; bus.write_en = 0; bus.addr = 0; bus.wdata = 0;
        bus.byte_transfer = 0; bus.instruction_fetch = 0;
        reset = 1'b1;
        #2;
        check32("reset stall", {31'd0, bus.stall}, 32'd0);
        check32("reset err", {31'd0, bus.err}, 32'd0);
        check32("reset rdata", bus.rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors: {rd, wr, addr, wdata, byte, fetch, stall, rdata, err}
        vecs.push_back('{0, 1, 32'h0300_0010, 32'hDEAD_BEEF, 0, 0, 2, 32'h0000_0000, 0});
        vecs.push_back('{1, 0, 32'h0300_0010, 32'h0, 0, 0, 2, 32'hDEAD_BEEF, 0});
        vecs.push_back('{0, 1, 32'h0300_0000, 32'hA0A0_A0A0, 0, 0, 2, 32'hDEAD_BEEF, 0});
        vecs.push_back('{0, 1, 32'h0300_0004, 32'hA4A4_A4A4, 0, 0, 1, 32'hDEAD_BEEF, 0});
        vecs.push_back('{0, 1, 32'h0300_0008, 32'hA8A8_A8A8, 0, 0, 1, 32'hDEAD_BEEF, 0});
        vecs.push_back('{1, 0, 32'h0300_0000, 32'h0, 0, 1, 2, 32'hA0A0_A0A0, 0});
        vecs.push_back('{1, 0, 32'h0300_0004, 32'h0, 0, 1, 1, 32'hA4A4_A4A4, 0});
        vecs.push_back('{1, 0, 32'h0300_0008, 32'h0, 0, 1, 1, 32'hA8A8_A8A8, 0});
        vecs.push_back('{1, 0, 32'h0300_0000, 32'h0, 0, 1, 2, 32'hA0A0_A0A0, 0});
        vecs.push_back('{1, 0, 32'h0300_0004, 32'h0, 0, 1, 1, 32'hA4A4_A4A4, 0});
        vecs.push_back('{1, 0, 32'h0300_0008, 32'h0, 0, 0, 2, 32'hA8A8_A8A8, 0});
        vecs.push_back('{0, 1, 32'h0300_0020, 32'h1122_3344, 0, 0, 2, 32'hA8A8_A8A8, 0});
        vecs.push_back('{0, 1, 32'h0300_0022, 32'hFFFF_FFAA, 1, 0, 2, 32'hA8A8_A8A8, 0});
        vecs.push_back('{1, 0, 32'h0300_0020, 32'h0, 0, 0, 2, 32'h11AA_3344, 0});
        vecs.push_back('{1, 0, 32'h0800_0000, 32'h0, 0, 0, 2, 32'h11AA_3344, 1});
        vecs.push_back('{0, 1, 32'h0800_0000, 32'h1234_5678, 0, 0, 2, 32'h11AA_3344, 1});
        vecs.push_back('{1, 0, 32'h0300_0000, 32'h0, 0, 0, 2, 32'hA0A0_A0A0, 0});
        vecs.push_back('{1, 1, 32'h0300_0000, 32'hBAD0_BAD0, 0, 0, 0, 32'hA0A0_A0A0, 1});
        vecs.push_back('{1, 0, 32'h0300_0004, 32'h0, 0, 0, 1, 32'hA4A4_A4A4, 0});
        vecs.push_back('{1, 0, 32'h02FF_FFFC, 32'h0, 0, 0, 2, 32'hA4A4_A4A4, 1});
        vecs.push_back('{0, 1, 32'h0300_7FFC, 32'hC0FF_EE00, 0, 0, 2, 32'hA4A4_A4A4, 0});
        vecs.push_back('{1, 0, 32'h0300_7FFC, 32'h0, 0, 0, 2, 32'hC0FF_EE00, 0});
        vecs.push_back('{1, 0, 32'h0300_8000, 32'h0, 0, 0, 1, 32'hC0FF_EE00, 1});
        vecs.push_back('{1, 0, 32'h0300_0022, 32'h0, 0, 0, 2, 32'h11AA_3344, 0});
        vecs.push_back('{1, 0, 32'h0300_0000, 32'h0, 0, 0, 2, 32'hA0A0_A0A0, 0});

        // Applied back to back: each request starts the cycle after the previous completes
        foreach (vecs[i]) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].bt,
                       vecs[i].fetch, st, rdv, ev);
            check_access($sformatf("vec%0d", i), st, rdv, ev, vecs[i].exp_stall,
                         vecs[i].exp_rdata, vecs[i].exp_err);
        end
        idle_cycle();
        check32("err single pulse", {31'd0, bus.err}, 32'd0);

        // Abort in WAIT: no commit, no err, history untouched
        run_access(0, 1, 32'h0300_000C, 32'h0C0C_0C0C, 0, 0, st, rdv, ev);
        check_access("abort pre", st, rdv, ev, 2, 32'hA0A0_A0A0, 0);
        bus.addr = 32'h0300_0010; bus.wdata = 32'h0BAD_F00D; bus.byte_transfer = 0;
        @(negedge clk);
        check32("abort idle stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        #1;
        check32("abort stall drop", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        check32("abort err", {31'd0, bus.err}, 32'd0);
        run_access(0, 1, 32'h0300_0014, 32'h1414_1414, 0, 0, st, rdv, ev);
        check_access("abort next nonseq", st, rdv, ev, 2, 32'hA0A0_A0A0, 0);
        run_access(1, 0, 32'h0300_0010, 32'h0, 0, 0, st, rdv, ev);
        check_access("abort no commit", st, rdv, ev, 2, 32'hDEAD_BEEF, 0);

        // Reset during WAIT of a write: immediate stall drop, no commit, history cleared
        run_access(0, 1, 32'h0300_0030, 32'h600D_F00D, 0, 0, st, rdv, ev);
        check_access("rst pre", st, rdv, ev, 2, 32'hDEAD_BEEF, 0);
        bus.wdata = 32'h0000_0055;
        @(negedge clk);
        @(posedge clk);
        #1;
        check32("rst wait stall", {31'd0, bus.stall}, 32'd1);
        reset = 1'b1;
        #1;
        check32("rst stall drop", {31'd0, bus.stall}, 32'd0);
        check32("rst rdata", bus.rdata, 32'd0);
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_access(0, 1, 32'h0300_0034, 32'h1212_1212, 0, 0, st, rdv, ev);
        check_access("rst first nonseq", st, rdv, ev, 2, 32'h0000_0000, 0);
        run_access(1, 0, 32'h0300_0030, 32'h0, 0, 0, st, rdv, ev);
        check_access("rst old word", st, rdv, ev, 2, 32'h600D_F00D, 0);
        idle_cycle();

        // Randomized traffic against the model, starting from a fresh reset
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hv = 1'b0; m_ha = 32'd0; m_hwr = 1'b0; m_hf = 1'b0; m_open = 32'd0;
        for (int k = 0; k < 16; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            int          es;
            logic [31:0] er;
            logic        ee;
            a = Base + 32'(4 * k);
            d = $urandom;
            model_step(0, 1, a, d, 0, 0, es, er, ee);
            run_access(0, 1, a, d, 0, 0, st, rdv, ev);
            check_access($sformatf("fill%0d", k), st, rdv, ev, es, er, ee);
        end
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        rd, wr, bt, f;
            int          es;
            logic [31:0] er;
            logic        ee;
            int          r;
            r  = $urandom_range(0, 99);
            rd = (r < 50);
            wr = (r < 5) || (r >= 50);
            bt = (r >= 85);
            f  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : m_hf;
            d  = $urandom;
            r  = $urandom_range(0, 99);
            if (r < 40 && m_hv && usable(m_ha + 32'd4)) begin
                a = m_ha + 32'd4;
            end else if (r < 52) begin
                case ($urandom_range(0, 2))
                    0:       a = Base - 32'd4;
                    1:       a = Base + 32'h8000;
                    default: a = 32'h0800_0000;
                endcase
            end else begin
                a = Base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            end
            model_step(rd, wr, a, d, bt, f, es, er, ee);
            run_access(rd, wr, a, d, bt, f, st, rdv, ev);
            check_access($sformatf("rnd%0d", n), st, rdv, ev, es, er, ee);
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 The parameter BASE_ADDR SHALL default to 32'h0300_0000 and set the byte address of word 0 of the backing store.
REQ-002 The parameter DEPTH_WORDS SHALL default to 8192 and set the backing-store size in 32-bit words (power of two).
REQ-003 The parameter N_WAIT SHALL default to 2 and set wait cycles for non-sequential accesses (0..15).
REQ-004 The parameter S_WAIT SHALL default to 1 and set wait cycles for sequential accesses (0..15).
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 addr  input  32  byte address from the bus master.
REQ-008 read_en  input  1  read request.
REQ-009 write_en  input  1  write request.
REQ-010 wdata  input  32  write data; a byte write carries its byte in bits [7:0].
REQ-011 byte_transfer  input  1  1 = byte write, 0 = word access.
REQ-012 instruction_fetch  input  1  the read is an opcode fetch.
REQ-013 rdata  output  32  read data, valid in the completing cycle.
REQ-014 stall  output  1  1 = access not complete; the master holds all inputs.
REQ-015 err  output  1  one-cycle registered pulse flagging a bad access.

Function
REQ-016 The block SHALL implement FSM states IDLE and WAIT with a 4-bit wait counter.
REQ-017 A request is read_en XOR write_en high; in IDLE a request SHALL select W = S_WAIT if sequential, else N_WAIT.
REQ-018 A request SHALL be sequential only if all of the following hold: a previous access completed; it was of the same kind (read/write); it had the same instruction_fetch value; and addr equals the previous addr + 4, mod 2^32.
REQ-019 If W = 0, stall SHALL be 0 and the access SHALL complete in the request cycle.
REQ-020 If W > 0, stall SHALL be 1 combinationally for W cycles (the IDLE cycle plus W-1 WAIT cycles). The access SHALL complete in cycle W+1 with stall = 0, and the FSM SHALL return to IDLE at that cycle's edge.
REQ-021 Back-to-back requests SHALL be accepted in IDLE on the cycle after a completion with no bubble.
REQ-022 In-range means BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS; the word index SHALL be (addr - BASE_ADDR)[..:2].
REQ-023 In an in-range completing read cycle, rdata SHALL equal the stored aligned word, unrotated; misalignment rotation belongs to the master.
REQ-024 An in-range word write SHALL commit wdata to the aligned word at the completing edge only.
REQ-025 An in-range byte write SHALL replace only byte lane addr[1:0] with wdata[7:0], leaving the other lanes unchanged.
REQ-026 An out-of-range read SHALL return open-bus data, defined as the last completed in-range read value.
REQ-027 An out-of-range write SHALL be dropped.
REQ-028 Both out-of-range cases SHALL apply W wait cycles and pulse err for one cycle after completion.
REQ-029 If read_en and write_en are both high in IDLE, the block SHALL perform no access, keep stall = 0 and pulse err; the cycle SHALL not count as a completed access.
REQ-030 If both enables drop while in WAIT, the block SHALL abort to IDLE with no commit, no err and no sequential-history update.
REQ-031 Outside completing read cycles, rdata SHALL hold the open-bus value.
REQ-032 Sequential history SHALL record the address, kind and fetch flag of every completed access, including out-of-range accesses.

Reset
REQ-033 Reset assertion SHALL immediately force the FSM to IDLE, counter = 0, stall = 0, err = 0, open-bus value = 0 and history invalid.
REQ-034 A write in progress when reset asserts SHALL not commit.
REQ-035 Backing-store contents SHALL not be cleared by reset.
REQ-036 The first request after reset deasserts SHALL be non-sequential.

Verification
REQ-037 Word write 0xDEADBEEF at 0x0300_0010 then read it: each access has stall high for 2 cycles; the read completes with rdata = 0xDEADBEEF.
REQ-038 Fetch reads at 0x0300_0000, then 0x0300_0004, then 0x0300_0008: stall lengths are 2, 1 and 1 cycles. Changing instruction_fetch on the third read instead gives a stall of 2 cycles.
REQ-039 Word 0x11223344 at 0x0300_0020, then a byte write of 0xAA at 0x0300_0022: a subsequent read returns 0x11AA3344.
REQ-040 Read 0x0300_0020, then read 0x0800_0000: the second read returns open-bus 0x11AA3344 and err pulses once; a write to 0x0800_0000 changes no stored word.
REQ-041 read_en and write_en both high: stall = 0, err pulses, memory unchanged.
REQ-042 Reset asserted in WAIT of a write of 0x55 to 0x0300_0030: stall drops immediately, and the old word still reads back after reset.
REQ-043 Enables dropped in WAIT: no commit, and the next request is non-sequential.
